// File: rtl/skew_deskew_bank_pkg.sv
// Shared types for the skew/deskew bank in front of and behind the MM array.
// Lane tap selection lives here so both array edges agree on lane ordering.
package skew_deskew_bank_pkg;

    localparam int SCALAR_W  = 8;
    localparam int DEF_LANES = 4;

    typedef logic [SCALAR_W-1:0] Scalar;

    typedef enum logic {
        SKEW_MODE   = 1'b0,
        DESKEW_MODE = 1'b1
    } SkewMode_e;

    typedef Scalar LaneVec_t [DEF_LANES];

    // Stage index feeding lane output: delay D(i) taps stage D(i)-1.
    function automatic int lane_tap(
        input SkewMode_e mode,
        input int        lane,
        input int        lanes
    );
        return (mode == SKEW_MODE) ? lane : (lanes - 1 - lane);
    endfunction

endpackage

// File: rtl/skew_deskew_bank_lane.sv
// One lane of the skew bank: a fixed-depth {valid, data} chain with a
// selectable output tap and an any-valid flag for the bank empty reduction.
module skew_lane
    import skew_deskew_bank_pkg::*;
#(
    parameter int DEPTH  = DEF_LANES,
    parameter int DATA_W = SCALAR_W,
    parameter int TAP_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [TAP_W-1:0]  i_tap,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_any
);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (i_en) begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_valid ? i_data : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    // Invalid stages already hold zero, so the tap needs no extra masking.
    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (TAP_W'(k) == i_tap) begin
                o_valid = r_valid[k];
                o_data  = r_data[k];
            end
        end
    end

    assign o_any = |r_valid;

endmodule

// File: rtl/skew_deskew_bank.sv
// Multi-lane skew/deskew shifter between operand buffers and the MM array
// edge; mode may only change while the whole bank is drained.
module skew_deskew_bank
    import skew_deskew_bank_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = SCALAR_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_in_valid,
    input  logic [LANES*DATA_W-1:0] i_in_data,
    input  logic                    i_mode_load,
    input  logic                    i_mode_in,
    output logic [LANES-1:0]        o_out_valid,
    output logic [LANES*DATA_W-1:0] o_out_data,
    output logic                    o_mode_q,
    output logic                    o_empty,
    output logic                    o_mode_err
);

    localparam int TAP_W = (LANES > 1) ? $clog2(LANES) : 1;

    SkewMode_e        r_mode;
    logic             r_mode_err;
    logic [LANES-1:0] w_any;
    logic             w_empty;
    logic [TAP_W-1:0] w_tap [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_tap[i] = TAP_W'(lane_tap(r_mode, i, LANES));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        skew_lane #(
            .DEPTH  (LANES),
            .DATA_W (DATA_W),
            .TAP_W  (TAP_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (i_en),
            .i_valid (i_in_valid),
            .i_data  (i_in_data[g*DATA_W +: DATA_W]),
            .i_tap   (w_tap[g]),
            .o_valid (o_out_valid[g]),
            .o_data  (o_out_data[g*DATA_W +: DATA_W]),
            .o_any   (w_any[g])
        );
    end

    assign w_empty = ~|w_any;

    // Mode switches ignore en: a drained bank may be retargeted while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode     <= SKEW_MODE;
            r_mode_err <= 1'b0;
        end else begin
            r_mode_err <= i_mode_load & ~w_empty;
            if (i_mode_load && w_empty) begin
                r_mode <= SkewMode_e'(i_mode_in);
            end
        end
    end

    assign o_mode_q   = r_mode;
    assign o_empty    = w_empty;
    assign o_mode_err = r_mode_err;

endmodule

// File: doc/skew_deskew_bank.md
Name: skew_deskew_bank

Overview:
- Parametrised multi-lane skew/deskew shifter feeding and draining the MM systolic array.
- Generalises the single-lane fixed-delay shift register: LANES lanes, per-lane delay chosen by a runtime mode (skew or deskew), global advance/stall, per-lane valid tracking, and an empty flag.
- Sits between the aligned operand buffers and the array edge (skew), or between the array's output edge and the result writer (deskew).

Parameters:
- LANES, 4, number of lanes (≥1); lane i delay ranges 1..LANES.
- DATA_W, 8, lane data width; must equal the width of the shared Scalar type.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  advance strobe; 0 = stall, all state held.
- in_valid  in  1  the aligned input vector is valid this cycle.
- in_data  in  LANES×DATA_W  aligned input vector; lane i occupies bits [i*DATA_W +: DATA_W].
- mode_load  in  1  request to update the mode register from mode_in.
- mode_in  in  1  0 = SKEW, 1 = DESKEW.
- out_valid  out  LANES  per-lane valid of the skewed output.
- out_data  out  LANES×DATA_W  skewed output vector.
- mode_q  out  1  active mode.
- empty  out  1  no valid token anywhere in the bank.
- mode_err  out  1  one-cycle pulse: mode_load was rejected.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything, including en:
  - all data and valid stages cleared to 0;
  - mode_q=SKEW, mode_err=0;
  - therefore out_data=0, out_valid=0, empty=1.
- Reset mid-stream discards all in-flight tokens; nothing is emitted afterwards.
- Lane i delay D(i): SKEW → i+1; DESKEW → LANES-i. The delay is counted in en=1 cycles, not clock cycles.
- Each lane is a LANES-deep chain of {valid, data} stages. Output is taken from stage D(i)-1 and is always registered; there is no combinational in→out path.
- On an edge with en=1:
  - stage0 ← {in_valid, in_valid ? in_data[i] : 0};
  - stage k+1 ← stage k.
- On an edge with en=0: every stage holds. in_valid and in_data are ignored, so a beat presented while en=0 is lost. The upstream block must hold its beat until en=1.
- out_valid[i] and out_data[i] are the tapped stage. Invalid slots always carry data 0 (zero-fill).
- empty is combinational: NOR of all valid stages in all lanes, including stages beyond the active tap.
- Mode change:
  - mode_load=1 and empty=1 → mode_q ← mode_in at that edge, regardless of en.
  - mode_load=1 and empty=0 → mode_q unchanged; mode_err=1 in the following cycle for one cycle.
  - mode_load=0 → mode_err=0 next cycle.
- Simultaneous mode_load and in_valid with en=1 while empty=1: both are accepted, and the new beat uses the new mode.
- Latency, SKEW: a beat accepted on en edge t appears on lane i after i+1 en edges.
- Latency, DESKEW: a vector skewed in SKEW mode re-aligns, appearing on all lanes simultaneously LANES en edges after its lane-0 element enters.
- Back-to-back beats (in_valid=1 on every en edge) give full throughput with no bubbles.
- LANES=1 degenerates to a 1-cycle register with enable in both modes.

Decomposition:
- Shared Types package:
  - Scalar (DATA_W-bit) typedef;
  - enum SkewMode_e {SKEW_MODE=0, DESKEW_MODE=1};
  - lane-vector typedef Scalar [LANES].
- Sub-module skew_lane:
  - one lane's LANES-deep {valid, data} chain with en and synchronous rst;
  - a tap-index input;
  - outputs: the tapped {valid, data} and an any-valid flag.
- Top level instantiates LANES lanes and contains the tap computation, the mode register/error logic and the empty reduction.

Test Plan (LANES=4, DATA_W=8):
1. Reset, then en=1, mode SKEW, single beat {0x10,0x11,0x12,0x13}. Lane0=0x10 valid 1 edge later, lane1=0x11 after 2, lane2=0x12 after 3, lane3=0x13 after 4. All other slots valid=0, data=0. empty=1 again 4 edges after the beat is accepted.
2. mode_load=1, mode_in=DESKEW while empty, then the same beat. Lane3=0x13 after 1 edge, lane0=0x10 after 4 edges. mode_q=1.
3. Continuous SKEW stream of beats n={n,n+1,n+2,n+3} for 8 cycles with en toggling 1,0,1,0… Outputs follow case 1 counted in en edges only. Outputs hold during en=0; no token is lost or duplicated.
4. Round trip: a SKEW-mode instance feeds a DESKEW-mode instance, stream of 6 beats. The second instance emits all 4 lanes valid together, each beat intact, 5 en edges after entering the first instance.
5. mode_load=1 with 2 tokens in flight → mode_err=1 for exactly one cycle and mode_q unchanged. Retry after empty=1 → accepted, mode_err=0.
6. rst=1 for one cycle while 3 beats are in flight, with en=1 and in_valid=1 asserted in the same cycle → out_valid=0 and out_data=0 on all lanes for the following 4 edges (in_valid=0), empty=1, mode_q=SKEW.
